// File: rtl/ram_reader_if.sv
// ram_reader_if: groups the RAM read port and the output stream of ram_reader.
// The master modport is the reader and the slave modport is the RAM/consumer side.
interface ram_reader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
);
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_q;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output ram_addr,
        output ram_we,
        input  ram_q,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  ram_addr,
        input  ram_we,
        output ram_q,
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/ram_reader.sv
// ram_reader: streams len consecutive words out of a single-port synchronous RAM.
// Absorbs the RAM's one-cycle read latency with a 3-entry FIFO so the output
// stream supports full backpressure without losing or repeating words.
// Optional feature macro: RAM_READER_STRIDE_EN adds a stride_i port; otherwise
// the address step is fixed at 1.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start_i; ram_addr holds its last value
// RUN   | issuing reads while words remain and FIFO + in-flight < 3
// DRAIN | all reads issued; waiting for the consumer to take the rest
module ram_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   len_i,
`ifdef RAM_READER_STRIDE_EN
    input  logic [ADDR_WIDTH-1:0] stride_i,
`endif
    output logic                  busy_o,
    output logic                  done_o,
    ram_reader_if.master          bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int CW = ADDR_WIDTH + 1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CW-1:0]         issue_cnt_q, issue_cnt_d;
    logic [CW-1:0]         accept_cnt_q, accept_cnt_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            count_q, count_d;
    logic                  valid_q, valid_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] fifo_q [3];
    logic [DATA_WIDTH-1:0] fifo_d [3];
    logic [ADDR_WIDTH-1:0] step_w;
    logic                  handshake_w;
    logic                  issue_w;
    logic [1:0]            base_w;

`ifdef RAM_READER_STRIDE_EN
    logic [ADDR_WIDTH-1:0] stride_q, stride_d;
    assign step_w = stride_q;
`else
    assign step_w = ADDR_WIDTH'(1);
`endif

    assign handshake_w = valid_q & bus.out_ready;
    // Issue decision looks only at registered occupancy, never at out_ready.
    assign issue_w     = (state_q == RUN) && (issue_cnt_q != '0) &&
                         (({1'b0, count_q} + {2'b00, inflight_q}) < 3'd3);

    assign bus.ram_addr  = addr_q;
    assign bus.ram_we    = 1'b0;
    assign bus.out_data  = fifo_q[0];
    assign bus.out_valid = valid_q;
    assign busy_o        = (state_q != IDLE);
    assign done_o        = done_q;

    // Next-state and datapath decisions for the FSM, counters and FIFO.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        issue_cnt_d  = issue_cnt_q;
        accept_cnt_d = accept_cnt_q;
        inflight_d   = 1'b0;
        done_d       = 1'b0;
`ifdef RAM_READER_STRIDE_EN
        stride_d     = stride_q;
`endif

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (len_i != '0) begin
                        state_d      = RUN;
                        addr_d       = base_addr_i;
                        issue_cnt_d  = len_i;
                        accept_cnt_d = len_i;
`ifdef RAM_READER_STRIDE_EN
                        stride_d     = stride_i;
`endif
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (issue_w) begin
                    addr_d      = addr_q + step_w;
                    issue_cnt_d = issue_cnt_q - CW'(1);
                    inflight_d  = 1'b1;
                    if (issue_cnt_q == CW'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_d = DRAIN;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (handshake_w) begin
            accept_cnt_d = accept_cnt_q - CW'(1);
            if (accept_cnt_q == CW'(1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end

        // Shift FIFO: entry 0 is the head, so out_data comes straight from a register.
        fifo_d[0] = handshake_w ? fifo_q[1] : fifo_q[0];
        fifo_d[1] = handshake_w ? fifo_q[2] : fifo_q[1];
        fifo_d[2] = fifo_q[2];
        base_w    = count_q - {1'b0, handshake_w};
        if (inflight_q) begin
            case (base_w)
                2'd0:    fifo_d[0] = bus.ram_q;
                2'd1:    fifo_d[1] = bus.ram_q;
                default: fifo_d[2] = bus.ram_q;
            endcase
        end
        count_d = base_w + {1'b0, inflight_q};
        valid_d = (count_d != 2'd0);
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Address, counters, FIFO and status registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q       <= '0;
            issue_cnt_q  <= '0;
            accept_cnt_q <= '0;
            inflight_q   <= 1'b0;
            count_q      <= 2'd0;
            valid_q      <= 1'b0;
            done_q       <= 1'b0;
            fifo_q       <= '{default: '0};
`ifdef RAM_READER_STRIDE_EN
            stride_q     <= '0;
`endif
        end else begin
            addr_q       <= addr_d;
            issue_cnt_q  <= issue_cnt_d;
            accept_cnt_q <= accept_cnt_d;
            inflight_q   <= inflight_d;
            count_q      <= count_d;
            valid_q      <= valid_d;
            done_q       <= done_d;
            fifo_q       <= fifo_d;
`ifdef RAM_READER_STRIDE_EN
            stride_q     <= stride_d;
`endif
        end
    end

endmodule

// File: tb/tb_ram_reader.sv
// tb_ram_reader: directed bench for ram_reader against a RAM preloaded with
// data = address[7:0].
module tb_ram_reader;
    localparam int DW = 8;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic          ready;
    logic [DW-1:0] mem [0:1023];
    logic [DW-1:0] q_r;
`ifdef RAM_READER_STRIDE_EN
    logic [AW-1:0] stride;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    assign bus.out_ready = ready;
    assign bus.ram_q     = q_r;

    always @(posedge clk) q_r <= mem[bus.ram_addr];

    ram_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .base_addr_i (base_addr),
        .len_i       (len),
`ifdef RAM_READER_STRIDE_EN
        .stride_i    (stride),
`endif
        .busy_o      (busy),
        .done_o      (done),
        .bus         (bus)
    );

    // Presents a start request that the DUT samples at the next rising edge (edge N).
    task automatic kick(input logic [AW-1:0] b, input logic [AW:0] l);
        @(negedge clk);
        start     = 1'b1;
        base_addr = b;
        len       = l;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.ram_addr !== 10'h000) begin failures++; $display("FAIL reset_ram_addr got=%h exp=000", bus.ram_addr); end
        checks++; if (bus.ram_we !== 1'b0) begin failures++; $display("FAIL reset_ram_we got=%b exp=0", bus.ram_we); end
        checks++; if (bus.out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", bus.out_data); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [DW-1:0] ed;
        kick(10'h010, 11'd4);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++; if (bus.ram_addr !== 10'h010) begin failures++; $display("FAIL basic_first_addr got=%h exp=010", bus.ram_addr); end
            end
            checks++; if (bus.out_valid !== (k >= 3 && k <= 6)) begin failures++; $display("FAIL basic_valid k=%0d got=%b", k, bus.out_valid); end
            if (k >= 3 && k <= 6) begin
                ed = 8'(8'h10 + k - 3);
                checks++; if (bus.out_data !== ed) begin failures++; $display("FAIL basic_data k=%0d got=%h exp=%h", k, bus.out_data, ed); end
            end
            checks++; if (done !== (k == 7)) begin failures++; $display("FAIL basic_done k=%0d got=%b", k, done); end
            checks++; if (busy !== (k <= 6)) begin failures++; $display("FAIL basic_busy k=%0d got=%b", k, busy); end
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        kick(10'h3FE, 11'd4);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k <= 4) begin
                ea = 10'(10'h3FE + k - 1);
                checks++; if (bus.ram_addr !== ea) begin failures++; $display("FAIL wrap_addr k=%0d got=%h exp=%h", k, bus.ram_addr, ea); end
            end
            if (k >= 3 && k <= 6) begin
                ed = 8'(8'hFE + k - 3);
                checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== ed) begin failures++; $display("FAIL wrap_data k=%0d got=%h/%b exp=%h", k, bus.out_data, bus.out_valid, ed); end
            end
            if (k == 7) begin
                checks++; if (done !== 1'b1) begin failures++; $display("FAIL wrap_done got=%b exp=1", done); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0]    pat;
        int            hs;
        int            adv;
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        logic          seen_done;
        pat        = 4'b1001;
        hs         = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        seen_done  = 1'b0;
        kick(10'h040, 11'd8);
        for (int k = 1; k <= 60 && !seen_done; k++) begin
            @(negedge clk);
            ready = pat[(k - 1) % 4];
            adv = int'(10'(bus.ram_addr - 10'h040));
            checks++; if (adv - hs > 3) begin failures++; $display("FAIL bp_outstanding k=%0d got=%0d exp<=3", k, adv - hs); end
            if (prev_stall) begin
                checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data) begin failures++; $display("FAIL bp_stable k=%0d got=%h/%b exp=%h/1", k, bus.out_data, bus.out_valid, prev_data); end
            end
            if (bus.out_valid && ready) begin
                checks++; if (bus.out_data !== 8'(8'h40 + hs)) begin failures++; $display("FAIL bp_data idx=%0d got=%h exp=%h", hs, bus.out_data, 8'(8'h40 + hs)); end
                hs++;
            end
            prev_stall = bus.out_valid && !ready;
            prev_data  = bus.out_data;
            if (done) seen_done = 1'b1;
        end
        ready = 1'b1;
        checks++; if (seen_done !== 1'b1) begin failures++; $display("FAIL bp_timeout got=%b exp=1", seen_done); end
        checks++; if (hs != 8) begin failures++; $display("FAIL bp_count got=%0d exp=8", hs); end
    endtask

    task automatic test_zero_len();
        kick(10'h155, 11'd0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++; if (done !== (k == 1)) begin failures++; $display("FAIL zl_done k=%0d got=%b", k, done); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zl_busy k=%0d got=%b exp=0", k, busy); end
            checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL zl_valid k=%0d got=%b exp=0", k, bus.out_valid); end
            checks++; if (bus.ram_addr !== 10'h048) begin failures++; $display("FAIL zl_addr k=%0d got=%h exp=048", k, bus.ram_addr); end
        end
    endtask

    task automatic test_start_ignored();
        logic [AW-1:0] ea;
        kick(10'h080, 11'd4);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            ea = (k <= 4) ? 10'(10'h080 + k - 1) : 10'h084;
            checks++; if (bus.ram_addr !== ea) begin failures++; $display("FAIL ign_addr k=%0d got=%h exp=%h", k, bus.ram_addr, ea); end
            checks++; if (bus.out_valid !== (k >= 3 && k <= 6)) begin failures++; $display("FAIL ign_valid k=%0d got=%b", k, bus.out_valid); end
            if (k >= 3 && k <= 6) begin
                checks++; if (bus.out_data !== 8'(8'h80 + k - 3)) begin failures++; $display("FAIL ign_data k=%0d got=%h exp=%h", k, bus.out_data, 8'(8'h80 + k - 3)); end
            end
            checks++; if (done !== (k == 7)) begin failures++; $display("FAIL ign_done k=%0d got=%b", k, done); end
            checks++; if (busy !== (k <= 6)) begin failures++; $display("FAIL ign_busy k=%0d got=%b", k, busy); end
            if (k == 2) begin
                start     = 1'b1;
                base_addr = 10'h200;
                len       = 11'd7;
            end
            if (k == 3) start = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        kick(10'h060, 11'd6);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k >= 3) begin
                checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(8'h60 + k - 3)) begin failures++; $display("FAIL rm_data k=%0d got=%h/%b exp=%h", k, bus.out_data, bus.out_valid, 8'(8'h60 + k - 3)); end
            end
        end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.ram_addr !== 10'h000) begin failures++; $display("FAIL rm_addr got=%h exp=000", bus.ram_addr); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rm_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_data !== 8'h00) begin failures++; $display("FAIL rm_out_data got=%h exp=00", bus.out_data); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rm_status got=%b%b exp=00", busy, done); end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++; if (done !== 1'b0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL rm_no_done got=%b/%b exp=0/0", done, bus.out_valid); end
        end
        kick(10'h020, 11'd2);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++; if (bus.out_valid !== (k == 3 || k == 4)) begin failures++; $display("FAIL rm2_valid k=%0d got=%b", k, bus.out_valid); end
            if (k == 3 || k == 4) begin
                checks++; if (bus.out_data !== 8'(8'h20 + k - 3)) begin failures++; $display("FAIL rm2_data k=%0d got=%h exp=%h", k, bus.out_data, 8'(8'h20 + k - 3)); end
            end
            checks++; if (done !== (k == 5)) begin failures++; $display("FAIL rm2_done k=%0d got=%b", k, done); end
        end
    endtask

`ifdef RAM_READER_STRIDE_EN
    task automatic test_stride();
        stride = 10'd3;
        kick(10'h000, 11'd4);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k >= 3 && k <= 6) begin
                checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(3 * (k - 3))) begin failures++; $display("FAIL stride_data k=%0d got=%h exp=%h", k, bus.out_data, 8'(3 * (k - 3))); end
            end
            if (k == 7) begin
                checks++; if (done !== 1'b1) begin failures++; $display("FAIL stride_done got=%b exp=1", done); end
            end
        end
        stride = 10'd1;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        len       = '0;
        ready     = 1'b1;
`ifdef RAM_READER_STRIDE_EN
        stride    = 10'd1;
`endif
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_start_ignored();
        test_reset_mid();
`ifdef RAM_READER_STRIDE_EN
        test_stride();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_reader.md
# ram_reader

Streaming read initiator for the single-port synchronous RAM, which has synchronous write and a registered read address. On `start` it walks `len` consecutive RAM addresses from `base_addr` and drives the RAM address port. It absorbs the RAM's one-cycle read latency and presents each word on a valid/ready output stream with full backpressure. It sits between a weight/input memory and the datapath that consumes its contents.

## Interface
- `DATA_WIDTH`, default 8: RAM word width.
- `ADDR_WIDTH`, default 10: RAM address width; the RAM holds 2**ADDR_WIDTH words.
- `clk`  in  1  Single clock, rising edge.
- `rst`  in  1  Reset, synchronous and active-high.
- `start`  in  1  Begin a transfer. Sampled only in IDLE.
- `base_addr`  in  ADDR_WIDTH  First address. Latched when `start` is accepted.
- `len`  in  ADDR_WIDTH+1  Number of words to read. Latched when `start` is accepted.
- `ram_addr`  out  ADDR_WIDTH  Drives the RAM `addr`. Registered.
- `ram_we`  out  1  Drives the RAM `we`. Constant 0.
- `ram_q`  in  DATA_WIDTH  RAM `q`.
- `out_data`  out  DATA_WIDTH  Stream data. Registered.
- `out_valid`  out  1  Stream valid. Registered.
- `out_ready`  in  1  Stream ready from the consumer.
- `busy`  out  1  High while a transfer is active.
- `done`  out  1  One-cycle pulse after the last word is accepted.

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE -> RUN when `start`=1 and `len`!=0.
  - Latch `base_addr` and `len`.
  - Issue counter is set to `len`; accept counter is set to `len`.
- IDLE with `start`=1 and `len`=0: stay in IDLE and pulse `done` next cycle. No address issued, no output.
- In RUN, one read is issued per cycle while issue counter != 0 and (buffer occupancy + in-flight) < 3.
  - Issuing means `ram_addr` holds the issued address for that cycle and the in-flight flag is set.
  - After each issue, `ram_addr` increments modulo 2**ADDR_WIDTH (wraps from all-ones to 0) and the issue counter decrements.
- In-flight data (`ram_q`, one cycle after issue) is pushed into a 3-entry FIFO. The FIFO head drives `out_data`/`out_valid`.
- A handshake (`out_valid`&`out_ready`) pops the FIFO and decrements the accept counter. Push and pop may occur in the same cycle.
- RUN -> DRAIN when the issue counter reaches 0.
- DRAIN -> IDLE on the handshake that brings the accept counter to 0. `done` pulses the following cycle.
- `start` while `busy`=1 is ignored.
- `out_data` is stable while `out_valid`=1 and `out_ready`=0.
- `out_valid` never drops without a handshake.
- `rst` at any time, including mid-transfer, has the same effect:
  - State goes to IDLE, the FIFO and in-flight flag are cleared, and the counters are zeroed.
  - Outstanding words are discarded and no `done` is produced.
- Reset values: `ram_addr`=0, `ram_we`=0, `out_data`=0, `out_valid`=0, `busy`=0, `done`=0.

## Timing
- `start` accepted at edge N:
  - `busy`=1 and `ram_addr`=`base_addr` from cycle N+1.
  - First word is on `ram_q` in cycle N+2.
  - `out_valid`=1 from cycle N+3 (3-cycle start-to-data latency).
- With `out_ready` held high: one word per cycle, no bubbles. A transfer of L words has its last handshake at cycle N+L+2.
- `done`=1 and `busy`=0 in the cycle after the last handshake. A new `start` is accepted in that same cycle.
- No combinational path from `out_ready` to `ram_addr`. The issue decision uses registered occupancy only.
- `ram_addr` holds its last value when idle.

## Configuration
- `RAM_READER_STRIDE_EN` defined:
  - Adds input port `stride` (ADDR_WIDTH), latched at `start`.
  - The address advances by `stride` modulo 2**ADDR_WIDTH per issue.
  - `stride`=0 rereads `base_addr` `len` times.
- Undefined: the port is absent and the stride is fixed at 1.

## Test plan
- RAM preloaded with data = address; `base_addr`=0x010, `len`=4, `out_ready`=1 -> `out_data` 0x10,0x11,0x12,0x13 on cycles N+3..N+6; `done` at N+7.
- `base_addr`=0x3FE, `len`=4 (ADDR_WIDTH=10) -> addresses 0x3FE,0x3FF,0x000,0x001; data in that order.
- `len`=8 with `out_ready` toggling 1,0,0,1,... -> all 8 words delivered in order, no loss or duplication. Occupancy + in-flight never exceeds 3. `out_data` stable while stalled.
- `len`=0 -> no `ram_addr` change, `out_valid` stays 0, `done` pulses at N+1. Separately, `start` pulsed mid-transfer -> ignored; the transfer completes unchanged.
- `rst` asserted at the third handshake of a `len`=6 transfer -> next cycle all outputs at reset values and no `done`. A following `start` with `base_addr`=0x020, `len`=2 returns 0x20,0x21.
- With `RAM_READER_STRIDE_EN`: `base_addr`=0, `stride`=3, `len`=4 -> data 0x00,0x03,0x06,0x09.
